// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StConv
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE    = 4'd9;

  // Iteration counter must hold 0..bin_w-1.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return (bin_w <= 32'd2) ? 32'd1 : $clog2(bin_w);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] digit_adj
);

  always_comb begin
    digit_adj = digit;
    if (digit >= ADD3_THRESH) begin
      digit_adj = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock, with
// overflow saturation and a leading-zero blanking mask for the display path.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          ready,
  output logic                          valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]             blank_mask,
  output logic                          overflow
);

  localparam int unsigned AccW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = cnt_width(BIN_W);
  localparam logic [CntW-1:0]   LastCnt   = CntW'(BIN_W - 1);
  localparam logic [DIGITS-1:0] MaskReset = ~(DIGITS'(1));

  if (BIN_W < 4 || BIN_W > 32) begin : g_bin_w_check
    $fatal(1, "bin2bcd_seq: BIN_W must be within 4..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_digits_check
    $fatal(1, "bin2bcd_seq: DIGITS must be within 1..10");
  end

  state_e           state_q, state_d;
  logic [BIN_W-1:0] shreg_q;
  logic [AccW-1:0]  acc_q, acc_adj, acc_next;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q, ovf_next;
  logic             accept, in_conv, last_iter;
  logic [AccW-1:0]  res_bcd;
  logic [DIGITS-1:0] res_mask;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit    (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_adj(acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // The bit leaving the top digit means the partial value no longer fits.
  assign acc_next = {acc_adj[AccW-2:0], shreg_q[BIN_W-1]};
  assign ovf_next = ovf_q | acc_adj[AccW-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StConv;
        end
      end
      StConv: begin
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready   = (state_q == StIdle);
    in_conv = (state_q == StConv);
  end

  assign accept    = ready & start;
  assign last_iter = in_conv & (cnt_q == LastCnt);

  // Final result as seen after the last iteration, saturated on overflow.
  always_comb begin
    logic all_zero;
    res_bcd  = ovf_next ? {DIGITS{BCD_NINE}} : acc_next;
    res_mask = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      all_zero    = all_zero & (res_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      res_mask[i] = all_zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      valid      <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= MaskReset;
      overflow   <= 1'b0;
    end else begin
      valid <= last_iter;
      if (accept) begin
        shreg_q <= bin_in;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (in_conv) begin
        shreg_q <= shreg_q << 1;
        acc_q   <= acc_next;
        cnt_q   <= cnt_q + CntW'(1);
        ovf_q   <= ovf_next;
      end
      if (last_iter) begin
        bcd_out    <= res_bcd;
        blank_mask <= res_mask;
        overflow   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table over 16/5 and 16/4 builds, handshake corner
// sequences, and a full sweep of a 7-bit / 2-digit build.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start_a, rdy_a, vld_a, ovf_a;
  logic [15:0] bin_a;
  logic [19:0] bcd_a;
  logic [4:0]  mask_a;

  logic        start_b, rdy_b, vld_b, ovf_b;
  logic [15:0] bin_b;
  logic [15:0] bcd_b;
  logic [3:0]  mask_b;

  logic        start_c, rdy_c, vld_c, ovf_c;
  logic [6:0]  bin_c;
  logic [7:0]  bcd_c;
  logic [1:0]  mask_c;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a), .ready(rdy_a), .valid(vld_a),
    .bcd_out(bcd_a), .blank_mask(mask_a), .overflow(ovf_a)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b), .ready(rdy_b), .valid(vld_b),
    .bcd_out(bcd_b), .blank_mask(mask_b), .overflow(ovf_b)
  );

  bin2bcd_seq #(.BIN_W(7), .DIGITS(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .bin_in(bin_c), .ready(rdy_c), .valid(vld_c),
    .bcd_out(bcd_c), .blank_mask(mask_c), .overflow(ovf_c)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          sel;
    int unsigned value;
    logic [39:0] bcd;
    logic [9:0]  mask;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return rdy_a;
      1:       return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  function automatic logic get_valid(input int sel);
    case (sel)
      0:       return vld_a;
      1:       return vld_b;
      default: return vld_c;
    endcase
  endfunction

  task automatic drive(input int sel, input int unsigned value, input logic st);
    case (sel)
      0:       begin bin_a = 16'(value); start_a = st; end
      1:       begin bin_b = 16'(value); start_b = st; end
      default: begin bin_c = 7'(value);  start_c = st; end
    endcase
  endtask

  task automatic convert(input int sel, input int unsigned value, output logic [39:0] bcd,
                         output logic [9:0] mask, output logic ovf, output int lat,
                         output int busy);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!get_ready(sel) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) timeout("ready_wait");
    drive(sel, value, 1'b1);
    @(posedge clk);
    #1;
    drive(sel, value, 1'b0);
    lat  = 0;
    busy = get_ready(sel) ? 0 : 1;
    while (!get_valid(sel) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!get_ready(sel)) busy++;
    end
    if (lat >= 200) timeout("valid_wait");
    case (sel)
      0:       begin bcd = 40'(bcd_a); mask = 10'(mask_a); ovf = ovf_a; end
      1:       begin bcd = 40'(bcd_b); mask = 10'(mask_b); ovf = ovf_b; end
      default: begin bcd = 40'(bcd_c); mask = 10'(mask_c); ovf = ovf_c; end
    endcase
  endtask

  initial begin
    logic [39:0] bcd;
    logic [9:0]  mask;
    logic        ovf;
    int          lat, busy, nvalid, guard, exp_lat;
    logic [7:0]  exp_c;

    vecs[0]  = '{0, 0,     40'h00000, 10'b11110, 1'b0};
    vecs[1]  = '{0, 65535, 40'h65535, 10'b00000, 1'b0};
    vecs[2]  = '{0, 1234,  40'h01234, 10'b10000, 1'b0};
    vecs[3]  = '{0, 59,    40'h00059, 10'b11100, 1'b0};
    vecs[4]  = '{0, 10,    40'h00010, 10'b11100, 1'b0};
    vecs[5]  = '{0, 9,     40'h00009, 10'b11110, 1'b0};
    vecs[6]  = '{1, 9999,  40'h09999, 10'b0000,  1'b0};
    vecs[7]  = '{1, 10000, 40'h09999, 10'b0000,  1'b1};
    vecs[8]  = '{1, 65535, 40'h09999, 10'b0000,  1'b1};
    vecs[9]  = '{1, 100,   40'h00100, 10'b1000,  1'b0};
    vecs[10] = '{1, 0,     40'h00000, 10'b1110,  1'b0};

    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a = '0; bin_b = '0; bin_c = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_ready", rdy_a, 1);
    check("reset_valid", vld_a, 0);
    check("reset_bcd", bcd_a, 0);
    check("reset_mask", mask_a, 5'b11110);
    check("reset_ovf", ovf_a, 0);

    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].sel, vecs[i].value, bcd, mask, ovf, lat, busy);
      check($sformatf("vec%0d_bcd", i), bcd, vecs[i].bcd);
      check($sformatf("vec%0d_mask", i), mask, vecs[i].mask);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), lat, 16);
      check($sformatf("vec%0d_busy", i), busy, 16);
    end

    // Valid is a single-cycle pulse and the result is held afterwards.
    convert(0, 65535, bcd, mask, ovf, lat, busy);
    @(posedge clk);
    #1;
    check("pulse_valid_low", vld_a, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_bcd", bcd_a, 20'h65535);
    check("hold_mask", mask_a, 0);
    check("hold_ready", rdy_a, 1);

    // start held high while bin_in changes every cycle.
    nvalid = 0;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      start_a = 1'b1;
      bin_a   = (k == 0) ? 16'd321 : (k == 17) ? 16'd4500 : 16'(60000 - k);
      @(posedge clk);
      #1;
      if (vld_a) begin
        nvalid++;
        if (nvalid == 1) begin
          check("held_start_first_edge", k, 16);
          check("held_start_first_bcd", bcd_a, 20'h00321);
        end else if (nvalid == 2) begin
          check("held_start_second_edge", k, 33);
          check("held_start_second_bcd", bcd_a, 20'h04500);
        end
      end
    end
    @(negedge clk);
    start_a = 1'b0;
    check("held_start_valid_count", nvalid, 2);
    guard = 0;
    while (!vld_a && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 40) timeout("third_valid_wait");
    else check("held_start_third_bcd", bcd_a, 20'h59966);

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    bin_a   = 16'd4321;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", rdy_a, 1);
    check("midrst_valid", vld_a, 0);
    check("midrst_bcd", bcd_a, 0);
    check("midrst_mask", mask_a, 5'b11110);
    check("midrst_ovf", ovf_a, 0);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (vld_a) nvalid++;
    end
    check("midrst_no_valid", nvalid, 0);
    convert(0, 59, bcd, mask, ovf, lat, busy);
    check("after_rst_bcd", bcd, 40'h00059);
    check("after_rst_mask", mask, 10'b11100);
    check("after_rst_latency", lat, 16);

    // Exhaustive 7-bit / 2-digit sweep.
    exp_lat = 7;
    for (int v = 0; v < 128; v++) begin
      exp_c = (v < 100) ? {4'(v / 10), 4'(v % 10)} : 8'h99;
      convert(2, v, bcd, mask, ovf, lat, busy);
      check($sformatf("sweep%0d_bcd", v), bcd, 40'(exp_c));
      check($sformatf("sweep%0d_mask", v), mask, (v < 10) ? 10'b10 : 10'b00);
      check($sformatf("sweep%0d_ovf", v), ovf, (v >= 100) ? 1 : 0);
      if (v == 0 || v == 127) check($sformatf("sweep%0d_latency", v), lat, exp_lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised, sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It performs one iteration per clock and uses a start/ready/valid handshake. It adds overflow detection and a leading-zero blanking mask for the 7-segment display path. It sits between the timekeeping/counter logic and the segment decoders, and converts counters wider than 7 bits (stopwatch hundredths, day counters) to an arbitrary number of BCD digits.

Parameters:
BIN_W, 16, width of the binary input; legal range 4..32.
DIGITS, 5, number of BCD output digits; legal range 1..10.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; synchronous, active-high.
start  input  1  request a conversion; accepted only when ready=1.
bin_in  input  BIN_W  unsigned binary operand; sampled on the accepting edge only.
ready  output  1  high when idle and able to accept start.
valid  output  1  one-cycle pulse; bcd_out, blank_mask and overflow are new this cycle.
bcd_out  output  4*DIGITS  packed BCD result; digit i = bits [4i+3:4i], digit 0 is least significant; held until the next result.
blank_mask  output  DIGITS  bit i=1 means digit i is a leading zero and is blanked.
overflow  output  1  result does not fit in DIGITS digits; held with bcd_out.

Behaviour:
- Reset (rst=1 at an edge): state←IDLE, ready=1, valid=0, bcd_out=0, blank_mask={DIGITS-1 ones, bit0=0}, overflow=0, iteration counter=0. Reset overrides start, including mid-conversion: the partial result is discarded and no valid pulse is produced.
- States: IDLE, CONV.
- IDLE: ready=1. An edge with start=1 loads the shift register with bin_in and clears the BCD accumulator, the counter and the overflow sticky bit. The state then goes to CONV and ready drops to 0. With start=0 the block stays in IDLE.
- CONV: ready=0. Each edge performs one iteration. First, every accumulator digit ≥5 gets +3 (all digits in parallel). Then {accumulator, shift register} shifts left by 1 and the counter increments.
  - If the bit shifted out of the top of digit DIGITS-1 is 1, the overflow sticky bit sets.
  - start is ignored in CONV; a new bin_in is not sampled.
- Completion: the iteration on the edge where the counter equals BIN_W-1 is the last one. On that edge the block registers bcd_out, blank_mask and overflow, sets valid=1 and returns to IDLE (ready=1).
  - Latency: acceptance at edge 0, valid high in the cycle after edge BIN_W.
  - Throughput: the next start can be accepted at edge BIN_W+1, giving one conversion per BIN_W+1 cycles.
- valid is high for exactly one cycle. There is no backpressure: the consumer must capture the result or use the held outputs.
- Overflow: if bin_in ≥ 10^DIGITS, then overflow=1 and bcd_out is saturated to all digits = 9. blank_mask is then all zeros.
- blank_mask: bit i=1 iff digits i..DIGITS-1 are all zero and i≠0. Digit 0 is never blanked, so a value of 0 shows "0".
- Every digit of bcd_out is always ≤9.
- Outputs change only on a valid edge or on reset.
- Elaboration checks: BIN_W out of its range is a fatal elaboration error. DIGITS out of its range is also a fatal elaboration error. DIGITS < ceil(BIN_W·log10(2)) is legal; overflow then covers the out-of-range inputs.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - state enum {IDLE, CONV};
  - BCD_DIGIT_W=4;
  - ADD3_THRESH=5;
  - BCD_NINE=4'd9;
  - a function that computes the counter width from BIN_W.
- Sub-module bcd_add3 is purely combinational: a 4-bit digit in, and out comes the digit +3 if ≥5, else unchanged. It is instantiated DIGITS times in a generate loop.
- The FSM, shift register, counter and output registers stay in bin2bcd_seq.

Test Plan:
1. BIN_W=16, DIGITS=5: start with bin_in=0 → valid exactly 16 cycles after acceptance; bcd_out=0x00000, blank_mask=5'b11110, overflow=0.
2. BIN_W=16, DIGITS=5: bin_in=65535 → bcd_out=0x65535, blank_mask=0, overflow=0; ready low for 16 cycles and high again with valid. Also bin_in=1234 → 0x01234, blank_mask=5'b10000.
3. BIN_W=16, DIGITS=4: bin_in=9999 → 0x9999, overflow=0; bin_in=10000 → 0x9999, overflow=1, blank_mask=0.
4. start held high continuously, with bin_in changed every cycle during CONV → only the value present at the accepting edge is converted. A second conversion is accepted at edge 17 and its valid arrives 16 cycles later; no extra valid pulses.
5. rst asserted at iteration 8 of a conversion of 4321 → no valid; outputs return to reset values; a following conversion of 59 → 0x00059, blank_mask=5'b11100.
6. Exhaustive sweep with BIN_W=7, DIGITS=2, inputs 0..127 → bcd_out matches value/10 and value%10 for 0..99, and overflow=1 for 100..127.
